// File: rtl/pe_result_reader.sv
`timescale 1ns/1ps
// pe_result_reader: reads a word range from the PE result memory and streams it out byte by byte.
// Defining RESULT_READER_CHECKSUM_EN adds a 16-bit running sum of accepted bytes on port checksum.
module pe_result_reader #(
    parameter int MAX_MEM_SIZE = 128,
    parameter int ADR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic [ADR_W-1:0] num_words,
    output logic             rd_en,
    output logic [ADR_W-1:0] rd_adr,
    input  logic [31:0]      rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef RESULT_READER_CHECKSUM_EN
    ,
    output logic [15:0]      checksum
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    localparam logic [ADR_W:0]   MAX_WORDS = (ADR_W+1)'(MAX_MEM_SIZE);
    localparam logic [ADR_W:0]   ONE_WORD  = (ADR_W+1)'(1);
    localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(MAX_MEM_SIZE - 1);

    state_t           state, state_d;
    logic [ADR_W-1:0] adr, adr_d;
    logic [ADR_W:0]   words_rem, words_rem_d;   // words left, including the one in flight
    logic [1:0]       byte_idx, byte_idx_d;
    logic [31:0]      word, word_d;
    logic             rd_en_d, out_valid_d, out_last_d, busy_d, done_d;
    logic [ADR_W-1:0] rd_adr_d;
    logic [7:0]       out_byte_d;
`ifdef RESULT_READER_CHECKSUM_EN
    logic [15:0]      checksum_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state;
        adr_d       = adr;
        words_rem_d = words_rem;
        byte_idx_d  = byte_idx;
        word_d      = word;
`ifdef RESULT_READER_CHECKSUM_EN
        checksum_d  = checksum;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef RESULT_READER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        adr_d       = ADR_W'(int'(base_adr) % MAX_MEM_SIZE);
                        words_rem_d = ({1'b0, num_words} > MAX_WORDS) ? MAX_WORDS : {1'b0, num_words};
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                word_d     = rd_data;
                byte_idx_d = '0;
                state_d    = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
`ifdef RESULT_READER_CHECKSUM_EN
                    checksum_d = checksum + {8'd0, out_byte};
`endif
                    if (byte_idx == 2'd3) begin
                        byte_idx_d = '0;
                        if (words_rem != ONE_WORD) begin
                            words_rem_d = words_rem - ONE_WORD;
                            adr_d       = (adr == LAST_ADR) ? '0 : adr + 1'b1;
                            state_d     = FETCH;
                        end else begin
                            words_rem_d = '0;
                            state_d     = DONE;
                        end
                    end else begin
                        byte_idx_d = byte_idx + 2'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the upcoming state so they leave the block registered.
        rd_en_d     = (state_d == FETCH);
        rd_adr_d    = (state_d == FETCH) ? adr_d : rd_adr;
        out_valid_d = (state_d == EMIT);
        out_byte_d  = (state_d == EMIT) ? word_d[{byte_idx_d, 3'b000} +: 8] : 8'd0;
        out_last_d  = (state_d == EMIT) && (byte_idx_d == 2'd3) && (words_rem_d == ONE_WORD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            adr       <= '0;
            words_rem <= '0;
            byte_idx  <= '0;
            word      <= '0;
            rd_en     <= 1'b0;
            rd_adr    <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            state     <= state_d;
            adr       <= adr_d;
            words_rem <= words_rem_d;
            byte_idx  <= byte_idx_d;
            word      <= word_d;
            rd_en     <= rd_en_d;
            rd_adr    <= rd_adr_d;
            out_valid <= out_valid_d;
            out_byte  <= out_byte_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef RESULT_READER_CHECKSUM_EN
            checksum  <= checksum_d;
`endif
        end
    end

endmodule
